// File: rtl/rv_cpu_top.sv
// rv_cpu_top: single-issue, in-order, 5-stage RV32I-subset core
// (IF, ID, EX, MEM, WB) fed by a zero-latency combinational instruction ROM.
// Configuration macro: RV_CPU_FORWARD_EN. When defined, EX operands are
// forwarded from MEM, then WB. When undefined, ID stalls on RAW hazards
// against EX and MEM.
//
// Stage flow semantics: each stage register carries a valid bit. A slot
// with valid=0 is a bubble and never writes the register file or redirects
// the PC. On a stall, IF and ID hold and EX receives a bubble. On a
// redirect from EX, IF/ID and ID/EX receive bubbles and pc_IF loads the
// target. A redirect wins over a stall in the same cycle.

module rv_cpu_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] rf_in [0:31];

  // Synchronous clear on reset; writes to x0 are dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_in[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      rf_in[wa_i] <= wd_i;
    end
  end

  // Write-through reads: a same-cycle WB write is visible to ID
  always_comb begin
    rd1_o = rf_in[ra1_i];
    rd2_o = rf_in[ra2_i];
    if (ra1_i == 5'd0) rd1_o = '0;
    else if (we_i && (wa_i == ra1_i)) rd1_o = wd_i;
    if (ra2_i == 5'd0) rd2_o = '0;
    else if (we_i && (wa_i == ra2_i)) rd2_o = wd_i;
  end
endmodule

module rv_cpu_top #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic [13:0] pc
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  // Stage registers
  logic        valid_if_q, valid_if_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] pc_id_q, pc_id_d, instr_id_q, instr_id_d;
  logic        valid_ex_q, valid_ex_d;
  logic [31:0] pc_ex_q, pc_ex_d, instr_ex_q, instr_ex_d;
  logic [31:0] rs1v_ex_q, rs1v_ex_d, rs2v_ex_q, rs2v_ex_d;
  logic        valid_mem_q, valid_mem_d, we_mem_q, we_mem_d;
  logic [4:0]  rd_mem_q, rd_mem_d;
  logic [31:0] res_mem_q, res_mem_d;
  logic        valid_wb_q, valid_wb_d, we_wb_q, we_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic [31:0] res_wb_q, res_wb_d;

  // Debug-visible nets
  logic        valid_IF, valid_ID, valid_EX, rf_we_WB;
  logic [31:0] pc_IF, instr_IF, pc_ID, instr_ID, pc_EX, alu_result_EX, rf_wd_WB;
  logic [4:0]  wR_WB;

  assign valid_IF = valid_if_q;
  assign pc_IF    = pc_if_q;
  assign instr_IF = instr;
  assign valid_ID = valid_id_q;
  assign pc_ID    = pc_id_q;
  assign instr_ID = instr_id_q;
  assign valid_EX = valid_ex_q;
  assign pc_EX    = pc_ex_q;
  assign rf_we_WB = valid_wb_q & we_wb_q;
  assign wR_WB    = rd_wb_q;
  assign rf_wd_WB = res_wb_q;
  assign pc       = pc_IF[15:2];

  // ID: register read
  logic [4:0]  rs1_id, rs2_id;
  logic [31:0] rd1_id, rd2_id;
  assign rs1_id = instr_ID[19:15];
  assign rs2_id = instr_ID[24:20];

  rv_cpu_regfile u_registerf (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (rf_we_WB),
    .wa_i  (wR_WB),
    .wd_i  (rf_wd_WB),
    .ra1_i (rs1_id),
    .ra2_i (rs2_id),
    .rd1_o (rd1_id),
    .rd2_o (rd2_id)
  );

  // EX: decode
  logic [6:0]  opc_ex;
  logic [2:0]  f3_ex;
  logic [4:0]  rd_ex;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_imm, is_reg, we_ex;
  logic [31:0] imm_i, imm_u, imm_b, imm_j, op_a, op_b, alu_b, alu_val, target;
  logic        taken, redirect, stall;

  assign opc_ex   = instr_ex_q[6:0];
  assign f3_ex    = instr_ex_q[14:12];
  assign rd_ex    = instr_ex_q[11:7];
  assign is_lui   = (opc_ex == OP_LUI);
  assign is_auipc = (opc_ex == OP_AUIPC);
  assign is_jal   = (opc_ex == OP_JAL);
  assign is_jalr  = (opc_ex == OP_JALR);
  assign is_br    = (opc_ex == OP_BR);
  assign is_imm   = (opc_ex == OP_IMM);
  assign is_reg   = (opc_ex == OP_REG);
  assign we_ex    = is_lui | is_auipc | is_jal | is_jalr | is_imm | is_reg;
  assign imm_i    = {{20{instr_ex_q[31]}}, instr_ex_q[31:20]};
  assign imm_u    = {instr_ex_q[31:12], 12'b0};
  assign imm_b    = {{19{instr_ex_q[31]}}, instr_ex_q[31], instr_ex_q[7],
                     instr_ex_q[30:25], instr_ex_q[11:8], 1'b0};
  assign imm_j    = {{11{instr_ex_q[31]}}, instr_ex_q[31], instr_ex_q[19:12],
                     instr_ex_q[20], instr_ex_q[30:21], 1'b0};

`ifdef RV_CPU_FORWARD_EN
  logic [4:0] rs1_ex, rs2_ex;
  assign rs1_ex = instr_ex_q[19:15];
  assign rs2_ex = instr_ex_q[24:20];
  assign stall  = 1'b0;

  // EX operand select: WB result, overridden by the younger MEM result
  always_comb begin
    op_a = rs1v_ex_q;
    op_b = rs2v_ex_q;
    if (valid_wb_q && we_wb_q && (rd_wb_q != 5'd0) && (rd_wb_q == rs1_ex)) op_a = res_wb_q;
    if (valid_wb_q && we_wb_q && (rd_wb_q != 5'd0) && (rd_wb_q == rs2_ex)) op_b = res_wb_q;
    if (valid_mem_q && we_mem_q && (rd_mem_q != 5'd0) && (rd_mem_q == rs1_ex)) op_a = res_mem_q;
    if (valid_mem_q && we_mem_q && (rd_mem_q != 5'd0) && (rd_mem_q == rs2_ex)) op_b = res_mem_q;
  end
`else
  logic [6:0] opc_id;
  logic       use1_id, use2_id, hz_ex, hz_mem;
  assign opc_id  = instr_ID[6:0];
  assign use1_id = (opc_id == OP_JALR) | (opc_id == OP_BR) | (opc_id == OP_IMM) | (opc_id == OP_REG);
  assign use2_id = (opc_id == OP_BR) | (opc_id == OP_REG);
  assign op_a    = rs1v_ex_q;
  assign op_b    = rs2v_ex_q;

  // RAW hazard detection against the in-flight EX and MEM writers
  always_comb begin
    hz_ex  = valid_EX && we_ex && (rd_ex != 5'd0) &&
             ((use1_id && (rd_ex == rs1_id)) || (use2_id && (rd_ex == rs2_id)));
    hz_mem = valid_mem_q && we_mem_q && (rd_mem_q != 5'd0) &&
             ((use1_id && (rd_mem_q == rs1_id)) || (use2_id && (rd_mem_q == rs2_id)));
    stall  = valid_ID && (hz_ex || hz_mem);
  end
`endif

  assign alu_b = is_reg ? op_b : imm_i;

  // ALU for OP / OP-IMM
  always_comb begin
    alu_val = '0;
    case (f3_ex)
      3'b000: alu_val = (is_reg && instr_ex_q[30]) ? (op_a - alu_b) : (op_a + alu_b);
      3'b001: alu_val = op_a << alu_b[4:0];
      3'b010: alu_val = {31'b0, $signed(op_a) < $signed(alu_b)};
      3'b011: alu_val = {31'b0, op_a < alu_b};
      3'b100: alu_val = op_a ^ alu_b;
      3'b101: begin
        if (instr_ex_q[30]) alu_val = $signed(op_a) >>> alu_b[4:0];
        else                alu_val = op_a >> alu_b[4:0];
      end
      3'b110: alu_val = op_a | alu_b;
      default: alu_val = op_a & alu_b;
    endcase
  end

  // EX result, branch condition and redirect target
  always_comb begin
    if (is_lui)               alu_result_EX = imm_u;
    else if (is_auipc)        alu_result_EX = pc_EX + imm_u;
    else if (is_jal | is_jalr) alu_result_EX = pc_EX + 32'd4;
    else                      alu_result_EX = alu_val;
    case (f3_ex)
      3'b000:  taken = (op_a == op_b);
      3'b001:  taken = (op_a != op_b);
      3'b100:  taken = ($signed(op_a) < $signed(op_b));
      3'b101:  taken = ($signed(op_a) >= $signed(op_b));
      3'b110:  taken = (op_a < op_b);
      3'b111:  taken = (op_a >= op_b);
      default: taken = 1'b0;
    endcase
    redirect = valid_EX && (is_jal || is_jalr || (is_br && taken));
    if (is_jalr) target = (op_a + imm_i) & ~32'd1;
    else         target = pc_EX + (is_jal ? imm_j : imm_b);
  end

  // Next-state for all stage registers: redirect, then stall, then advance
  always_comb begin
    valid_if_d = 1'b1;
    pc_if_d    = pc_IF;
    valid_id_d = valid_ID;
    pc_id_d    = pc_ID;
    instr_id_d = instr_ID;
    valid_ex_d = valid_ID && !stall;
    pc_ex_d    = pc_ID;
    instr_ex_d = instr_ID;
    rs1v_ex_d  = rd1_id;
    rs2v_ex_d  = rd2_id;
    if (redirect) begin
      pc_if_d    = target;
      valid_id_d = 1'b0;
      valid_ex_d = 1'b0;
    end else if (!stall) begin
      if (valid_IF) pc_if_d = pc_IF + 32'd4;
      valid_id_d = valid_IF;
      pc_id_d    = pc_IF;
      instr_id_d = instr_IF;
    end
    valid_mem_d = valid_EX;
    we_mem_d    = we_ex;
    rd_mem_d    = rd_ex;
    res_mem_d   = alu_result_EX;
    valid_wb_d  = valid_mem_q;
    we_wb_d     = we_mem_q;
    rd_wb_d     = rd_mem_q;
    res_wb_d    = res_mem_q;
  end

  // Stage registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_if_q <= 1'b0;  pc_if_q    <= RESET_PC;
      valid_id_q <= 1'b0;  pc_id_q    <= '0;  instr_id_q <= '0;
      valid_ex_q <= 1'b0;  pc_ex_q    <= '0;  instr_ex_q <= '0;
      rs1v_ex_q  <= '0;    rs2v_ex_q  <= '0;
      valid_mem_q <= 1'b0; we_mem_q   <= 1'b0; rd_mem_q <= '0; res_mem_q <= '0;
      valid_wb_q <= 1'b0;  we_wb_q    <= 1'b0; rd_wb_q  <= '0; res_wb_q  <= '0;
    end else begin
      valid_if_q <= valid_if_d;  pc_if_q    <= pc_if_d;
      valid_id_q <= valid_id_d;  pc_id_q    <= pc_id_d;  instr_id_q <= instr_id_d;
      valid_ex_q <= valid_ex_d;  pc_ex_q    <= pc_ex_d;  instr_ex_q <= instr_ex_d;
      rs1v_ex_q  <= rs1v_ex_d;   rs2v_ex_q  <= rs2v_ex_d;
      valid_mem_q <= valid_mem_d; we_mem_q  <= we_mem_d; rd_mem_q <= rd_mem_d; res_mem_q <= res_mem_d;
      valid_wb_q <= valid_wb_d;  we_wb_q    <= we_wb_d;  rd_wb_q  <= rd_wb_d;  res_wb_q  <= res_wb_d;
    end
  end
endmodule

// File: tb/tb_rv_cpu_top.sv
// Directed bench for rv_cpu_top: small programs in a combinational ROM,
// register-file contents and commit timing checked against hand-computed values.
module tb_rv_cpu_top;
  localparam logic [6:0] OPI = 7'b0010011, OLUI = 7'b0110111, OAUI = 7'b0010111;
  localparam logic [6:0] OJALR = 7'b1100111, OJAL = 7'b1101111, OBR = 7'b1100011;
`ifdef RV_CPU_FORWARD_EN
  localparam int RAW_X2 = 6, RAW_X3 = 7, BR_X7 = 9;
`else
  localparam int RAW_X2 = 8, RAW_X3 = 11, BR_X7 = 11;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr;
  logic [13:0] pc;
  logic [31:0] rom [0:16383];
  logic [31:0] exp_q[$];
  logic [31:0] got, want;
  int total = 0;
  int bad = 0;

  rv_cpu_top #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .instr (instr),
    .pc    (pc)
  );

  // Clock / ROM
  always #5 clk = ~clk;
  assign instr = rom[pc];

  function automatic logic [31:0] enc_i(input int rd, input int rs1, input int f3, input int imm, input logic [6:0] op);
    logic [31:0] vi, vd, vs, vf;
    vi = imm; vd = rd; vs = rs1; vf = f3;
    return {vi[11:0], vs[4:0], vf[2:0], vd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rd, input int rs1, input int rs2, input int f3);
    logic [31:0] v7, vd, v1, v2, vf;
    v7 = f7; vd = rd; v1 = rs1; v2 = rs2; vf = f3;
    return {v7[6:0], v2[4:0], v1[4:0], vf[2:0], vd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int off);
    logic [31:0] o, v1, v2, vf;
    o = off; v1 = rs1; v2 = rs2; vf = f3;
    return {o[12], o[10:5], v2[4:0], v1[4:0], vf[2:0], o[4:1], o[11], OBR};
  endfunction

  function automatic logic [31:0] enc_u(input int rd, input int imm20, input logic [6:0] op);
    logic [31:0] vi, vd;
    vi = imm20; vd = rd;
    return {vi[19:0], vd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_j(input int rd, input int off);
    logic [31:0] o, vd;
    o = off; vd = rd;
    return {o[20], o[10:1], o[11], o[19:12], vd[4:0], OJAL};
  endfunction

  // Driver tasks
  task automatic clear_rom();
    for (int i = 0; i < 16384; i++) rom[i] = 32'h0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_and_release();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_clear();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(32'h0);
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = enc_i(1, 0, 0, 5, OPI);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (pc !== 14'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
    total++; if ({dut.valid_IF, dut.valid_ID, dut.valid_EX, dut.rf_we_WB} !== 4'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0000", {dut.valid_IF, dut.valid_ID, dut.valid_EX, dut.rf_we_WB}); end
    exp_clear();
    for (int i = 0; i < 32; i++) begin
      got = dut.u_registerf.rf_in[i]; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_rf x%0d got=%h exp=%h", i, got, want); end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (pc !== 14'h0) begin bad++; $display("FAIL release_pc got=%h exp=0", pc); end
    total++; if (dut.valid_IF !== 1'b1) begin bad++; $display("FAIL release_valid_if got=%b exp=1", dut.valid_IF); end
  endtask

  task automatic test_addi_latency();
    clear_rom();
    rom[0] = enc_i(1, 0, 0, 5, OPI);
    reset_and_release();
    tick(4);
    total++; if (dut.u_registerf.rf_in[1] !== 32'h0) begin bad++; $display("FAIL addi_early got=%h exp=0", dut.u_registerf.rf_in[1]); end
    total++; if ({dut.rf_we_WB, dut.wR_WB, dut.rf_wd_WB} !== {1'b1, 5'd1, 32'd5}) begin
      bad++; $display("FAIL addi_wb got=%b/%0d/%h exp=1/1/5", dut.rf_we_WB, dut.wR_WB, dut.rf_wd_WB); end
    tick(1);
    total++; if (dut.u_registerf.rf_in[1] !== 32'h5) begin bad++; $display("FAIL addi_commit got=%h exp=5", dut.u_registerf.rf_in[1]); end
    tick(10);
    exp_clear(); exp_q[1] = 32'h5;
    for (int i = 0; i < 32; i++) begin
      got = dut.u_registerf.rf_in[i]; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL addi_rf x%0d got=%h exp=%h", i, got, want); end
    end
  endtask

  task automatic load_raw();
    clear_rom();
    rom[0] = enc_i(1, 0, 0, 5, OPI);
    rom[1] = enc_r(0, 2, 1, 1, 0);
    rom[2] = enc_r(32, 3, 2, 1, 0);
  endtask

  task automatic test_back_to_back();
    load_raw();
    reset_and_release();
    tick(RAW_X2 - 1);
    total++; if (dut.u_registerf.rf_in[2] !== 32'h0) begin bad++; $display("FAIL raw_x2_early got=%h exp=0", dut.u_registerf.rf_in[2]); end
    tick(1);
    total++; if (dut.u_registerf.rf_in[2] !== 32'd10) begin bad++; $display("FAIL raw_x2 got=%h exp=a", dut.u_registerf.rf_in[2]); end
    tick(RAW_X3 - RAW_X2 - 1);
    total++; if (dut.u_registerf.rf_in[3] !== 32'h0) begin bad++; $display("FAIL raw_x3_early got=%h exp=0", dut.u_registerf.rf_in[3]); end
    tick(1);
    total++; if (dut.u_registerf.rf_in[3] !== 32'd5) begin bad++; $display("FAIL raw_x3 got=%h exp=5", dut.u_registerf.rf_in[3]); end
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0] = enc_i(1, 0, 0, 1, OPI);
    rom[1] = enc_b(0, 1, 1, 12);
    rom[2] = enc_i(5, 0, 0, 7, OPI);
    rom[3] = enc_i(6, 0, 0, 7, OPI);
    rom[4] = enc_i(7, 0, 0, 9, OPI);
    reset_and_release();
    tick(BR_X7 - 1);
    total++; if (dut.u_registerf.rf_in[7] !== 32'h0) begin bad++; $display("FAIL beq_x7_early got=%h exp=0", dut.u_registerf.rf_in[7]); end
    tick(1);
    total++; if (dut.u_registerf.rf_in[7] !== 32'h9) begin bad++; $display("FAIL beq_x7 got=%h exp=9", dut.u_registerf.rf_in[7]); end
    tick(10);
    exp_clear(); exp_q[1] = 32'h1; exp_q[7] = 32'h9;
    for (int i = 0; i < 32; i++) begin
      got = dut.u_registerf.rf_in[i]; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL beq_rf x%0d got=%h exp=%h", i, got, want); end
    end
  endtask

  task automatic test_cond_branch();
    clear_rom();
    rom[0] = enc_i(1, 0, 0, -1, OPI);
    rom[1] = enc_b(4, 1, 0, 8);
    rom[2] = enc_i(2, 0, 0, 1, OPI);
    rom[3] = enc_b(6, 1, 0, 8);
    rom[4] = enc_i(3, 0, 0, 3, OPI);
    rom[5] = enc_b(5, 0, 1, 8);
    rom[6] = enc_i(4, 0, 0, 4, OPI);
    rom[7] = enc_i(5, 0, 0, 5, OPI);
    reset_and_release();
    tick(40);
    exp_clear(); exp_q[1] = 32'hFFFF_FFFF; exp_q[3] = 32'h3; exp_q[5] = 32'h5;
    for (int i = 0; i < 32; i++) begin
      got = dut.u_registerf.rf_in[i]; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL cond_rf x%0d got=%h exp=%h", i, got, want); end
    end
  endtask

  task automatic test_jal();
    clear_rom();
    rom[0] = enc_j(1, 8);
    rom[1] = enc_i(2, 0, 0, 3, OPI);
    rom[2] = enc_i(3, 0, 0, 4, OPI);
    reset_and_release();
    tick(2);
    total++; if (pc !== 14'd2) begin bad++; $display("FAIL jal_seq_pc got=%0d exp=2", pc); end
    tick(1);
    total++; if (pc !== 14'd2) begin bad++; $display("FAIL jal_target_pc got=%0d exp=2", pc); end
    total++; if (dut.valid_ID !== 1'b0) begin bad++; $display("FAIL jal_flush_id got=%b exp=0", dut.valid_ID); end
    tick(1);
    total++; if (pc !== 14'd3) begin bad++; $display("FAIL jal_resume_pc got=%0d exp=3", pc); end
    tick(10);
    exp_clear(); exp_q[1] = 32'h4; exp_q[3] = 32'h4;
    for (int i = 0; i < 32; i++) begin
      got = dut.u_registerf.rf_in[i]; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL jal_rf x%0d got=%h exp=%h", i, got, want); end
    end
  endtask

  task automatic test_jalr();
    clear_rom();
    rom[0] = enc_i(1, 0, 0, 13, OPI);
    rom[1] = enc_i(2, 1, 0, 0, OJALR);
    rom[2] = enc_i(3, 0, 0, 1, OPI);
    rom[3] = enc_i(4, 0, 0, 2, OPI);
    reset_and_release();
    tick(20);
    exp_clear(); exp_q[1] = 32'd13; exp_q[2] = 32'h8; exp_q[4] = 32'h2;
    for (int i = 0; i < 32; i++) begin
      got = dut.u_registerf.rf_in[i]; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL jalr_rf x%0d got=%h exp=%h", i, got, want); end
    end
  endtask

  task automatic test_lui_x0();
    clear_rom();
    rom[0] = enc_i(0, 0, 0, 5, OPI);
    rom[1] = enc_u(4, 32'hFFFFF, OLUI);
    rom[2] = enc_i(4, 4, 0, -1, OPI);
    rom[3] = enc_i(8, 4, 2, 0, OPI);
    rom[4] = 32'hFFFF_FFA3;
    reset_and_release();
    tick(25);
    exp_clear(); exp_q[4] = 32'hFFFF_EFFF; exp_q[8] = 32'h1;
    for (int i = 0; i < 32; i++) begin
      got = dut.u_registerf.rf_in[i]; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL lui_rf x%0d got=%h exp=%h", i, got, want); end
    end
  endtask

  task automatic test_alu();
    clear_rom();
    rom[0]  = enc_i(1, 0, 0, -8, OPI);
    rom[1]  = enc_i(2, 1, 5, 32'h401, OPI);
    rom[2]  = enc_i(3, 1, 5, 28, OPI);
    rom[3]  = enc_i(4, 1, 3, 1, OPI);
    rom[4]  = enc_i(5, 1, 4, -1, OPI);
    rom[5]  = enc_i(6, 5, 1, 4, OPI);
    rom[6]  = enc_r(0, 7, 5, 6, 6);
    rom[7]  = enc_r(0, 8, 7, 1, 7);
    rom[8]  = enc_r(0, 9, 5, 1, 3);
    rom[9]  = enc_r(0, 10, 1, 5, 2);
    rom[10] = enc_r(32, 11, 1, 5, 5);
    rom[11] = enc_r(32, 12, 5, 1, 0);
    rom[12] = enc_r(0, 13, 1, 5, 0);
    rom[13] = enc_r(0, 14, 1, 5, 5);
    rom[14] = enc_r(0, 15, 5, 5, 1);
    rom[15] = enc_r(0, 16, 6, 5, 4);
    rom[16] = enc_i(17, 1, 2, -9, OPI);
    rom[17] = enc_u(18, 1, OAUI);
    rom[18] = enc_i(19, 0, 3, 1, OPI);
    reset_and_release();
    tick(90);
    exp_clear();
    exp_q[1]  = 32'hFFFF_FFF8; exp_q[2]  = 32'hFFFF_FFFC; exp_q[3]  = 32'hF;
    exp_q[5]  = 32'h7;         exp_q[6]  = 32'h70;        exp_q[7]  = 32'h77;
    exp_q[8]  = 32'h70;        exp_q[9]  = 32'h1;         exp_q[10] = 32'h1;
    exp_q[11] = 32'hFFFF_FFFF; exp_q[12] = 32'hF;         exp_q[13] = 32'hFFFF_FFFF;
    exp_q[14] = 32'h01FF_FFFF; exp_q[15] = 32'h380;       exp_q[16] = 32'h77;
    exp_q[18] = 32'h1044;      exp_q[19] = 32'h1;
    for (int i = 0; i < 32; i++) begin
      got = dut.u_registerf.rf_in[i]; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL alu_rf x%0d got=%h exp=%h", i, got, want); end
    end
  endtask

  task automatic test_mid_reset();
    load_raw();
    reset_and_release();
    tick(7);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (pc !== 14'h0) begin bad++; $display("FAIL midrst_pc got=%h exp=0", pc); end
    total++; if ({dut.valid_IF, dut.valid_ID, dut.valid_EX, dut.rf_we_WB} !== 4'b0) begin
      bad++; $display("FAIL midrst_valid got=%b exp=0000", {dut.valid_IF, dut.valid_ID, dut.valid_EX, dut.rf_we_WB}); end
    exp_clear();
    for (int i = 0; i < 32; i++) begin
      got = dut.u_registerf.rf_in[i]; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL midrst_rf x%0d got=%h exp=%h", i, got, want); end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if ((pc !== 14'h0) || (dut.valid_IF !== 1'b1)) begin
      bad++; $display("FAIL midrst_release got=%h/%b exp=0/1", pc, dut.valid_IF); end
    tick(25);
    exp_clear(); exp_q[1] = 32'h5; exp_q[2] = 32'hA; exp_q[3] = 32'h5;
    for (int i = 0; i < 32; i++) begin
      got = dut.u_registerf.rf_in[i]; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL midrst_rerun x%0d got=%h exp=%h", i, got, want); end
    end
  endtask

  // Sequencer and final report
  initial begin
    clear_rom();
    test_reset();
    test_addi_latency();
    test_back_to_back();
    test_branch();
    test_cond_branch();
    test_jal();
    test_jalr();
    test_lui_x0();
    test_alu();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_cpu_top.md
RV_CPU_TOP -- requirements
Module: rv_cpu_top

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; byte address of the first fetched instruction.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low; clock clk.
REQ-004 instr  input  32  instruction word from the external instruction ROM, valid in the same cycle as pc (combinational ROM, zero-latency read).
REQ-005 pc  output  14  word address to the instruction ROM: PC_IF[15:2].
REQ-006 Debug-visible internal nets SHALL exist by these names: valid_IF, pc_IF, instr_IF, valid_ID, pc_ID, instr_ID, valid_EX, pc_EX, alu_result_EX, rf_we_WB, wR_WB[4:0], rf_wd_WB; register file instance u_registerf with array rf_in[0:31][31:0].

Function
REQ-007 The block SHALL be a single-issue, in-order, 5-stage pipeline: IF, ID, EX, MEM, WB, one instruction per stage, each stage carrying a valid bit.
REQ-008 Supported RV32I subset: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, OP-IMM (ADDI..SRAI), OP (ADD..AND); every other opcode SHALL execute as a NOP with no register write.
REQ-009 Arithmetic SHALL be 32-bit two's complement with wrap-around; shift amount = low 5 bits; SLT/SLTI signed, SLTU/SLTIU unsigned.
REQ-010 IF: pc_IF advances by 4 each cycle unless stalled or redirected; instr_IF = instr.
REQ-011 Branches and jumps SHALL resolve in EX; on taken/jump, pc_IF loads the target next cycle and IF/ID contents are flushed (valid cleared); penalty is 2 bubbles; not-taken costs 0.
REQ-012 JAL/JALR write pc+4 to rd; JALR target = (rs1+imm) & ~1.
REQ-013 alu_result_EX SHALL hold the EX-stage result (ALU value, or pc+4 for jumps, or imm for LUI).
REQ-014 MEM stage SHALL pass results through unchanged (no data memory port).
REQ-015 WB: when rf_we_WB=1 and wR_WB!=0, rf_in[wR_WB] <= rf_wd_WB at the rising edge; writes to x0 are discarded; rf_in[0] reads 0 always.
REQ-016 Register file reads SHALL be write-through: an ID read of the register being written in WB the same cycle returns the new value.
REQ-017 Latency: an instruction presented on instr in cycle n SHALL commit its register write at the rising edge ending cycle n+4, absent stalls/flushes.
REQ-018 A redirect from EX SHALL take priority over any stall in the same cycle.
REQ-019 Bubbles (flushed or stalled slots) SHALL have valid=0 and SHALL never write the register file or redirect the PC.

Reset
REQ-020 While rst_n=0 at a rising edge: pc_IF=RESET_PC, all stage valid bits 0, all rf_in entries 0, all pipeline registers 0.
REQ-021 First rising edge with rst_n=1: pc output equals RESET_PC[15:2]; the instruction at RESET_PC enters IF with valid_IF=1.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight instructions with no further register writes after that edge.

Configuration
REQ-023 Macro RV_CPU_FORWARD_EN: defined -> EX operands forwarded from MEM and WB results (MEM has priority), dependent ALU instructions run back-to-back with no stall.
REQ-024 Without RV_CPU_FORWARD_EN: ID SHALL stall (hold IF and ID, insert EX bubble) while any valid EX or MEM instruction writes a nonzero rd equal to the rs1/rs2 in use; WB hazards are covered by REQ-016.
REQ-025 Architectural results SHALL be identical with and without the macro; only cycle counts differ.

Verification
REQ-026 ROM: addi x1,x0,5; after reset -> x1=0x00000005 written at 5th rising edge after release; all other registers 0.
REQ-027 addi x1,x0,5; add x2,x1,x1; sub x3,x2,x1 -> x2=10, x3=5; with RV_CPU_FORWARD_EN writes on consecutive cycles, without it extra stall cycles but same values.
REQ-028 addi x1,x0,1; beq x1,x1,+12; addi x5,x0,7; addi x6,x0,7; addi x7,x0,9 -> x5=0, x6=0, x7=9; 2 flushed slots.
REQ-029 jal x1,+8 at pc 0 -> x1=0x4, instruction at 0x4 not committed, fetch resumes at 0x8.
REQ-030 addi x0,x0,5; lui x4,0xFFFFF; addi x4,x4,-1 -> x0=0, x4=0xFFFFEFFF; slti x8,x4,0 -> x8=1.
REQ-031 Assert rst_n=0 for one edge mid-program -> all rf_in cleared, pc returns to RESET_PC[15:2], program re-executes from start.
